alu_op_decoder: RTL and testbench

- Registered decode stage that turns RV32I integer instructions (OP, OP-IMM, LUI) plus register operands into the 4-bit `cntl` code and A/B operands the combinational ALU consumes.
- Sits directly upstream of the ALU in the execute path.
- Uses valid/ready on both sides with a 2-entry output buffer, so the upstream ready is registered and throughput is one instruction per cycle.
- Flags undecodable instructions and keeps a saturating count of them.

---
 rtl/alu_op_decoder.sv | 190 +++++++++++++++++++
 tb/tb_alu_op_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder.sv
// Registered RV32I decode stage (OP, OP-IMM, LUI) feeding the execute-stage ALU.
// Decoded entries pass through a 2-entry FIFO, so in_ready depends only on the registered count.
module alu_op_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_cntl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      rd,
    output logic            illegal,
    output logic [15:0]     illegal_count
);

    localparam logic [3:0] CNTL_AND   = 4'b0000;
    localparam logic [3:0] CNTL_OR    = 4'b0001;
    localparam logic [3:0] CNTL_XOR   = 4'b0010;
    localparam logic [3:0] CNTL_ADD   = 4'b0011;
    localparam logic [3:0] CNTL_SUB   = 4'b0100;
    localparam logic [3:0] CNTL_SLT   = 4'b0101;
    localparam logic [3:0] CNTL_SLTU  = 4'b0110;
    localparam logic [3:0] CNTL_SLL   = 4'b0111;
    localparam logic [3:0] CNTL_SRA   = 4'b1000;
    localparam logic [3:0] CNTL_SRL   = 4'b1001;
    localparam logic [3:0] CNTL_PASSB = 4'b1010;
    localparam logic [3:0] CNTL_ILL   = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]      cntl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    entry_t dec;

    always_comb begin
        dec      = '0;
        dec.cntl = CNTL_ILL;
        dec.ill  = 1'b1;
        dec.rd   = instr[11:7];
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec.ill = 1'b0;
                    unique case (funct3)
                        3'b000:  dec.cntl = CNTL_ADD;
                        3'b001:  dec.cntl = CNTL_SLL;
                        3'b010:  dec.cntl = CNTL_SLT;
                        3'b011:  dec.cntl = CNTL_SLTU;
                        3'b100:  dec.cntl = CNTL_XOR;
                        3'b101:  dec.cntl = CNTL_SRL;
                        3'b110:  dec.cntl = CNTL_OR;
                        default: dec.cntl = CNTL_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.ill  = 1'b0;
                    dec.cntl = CNTL_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.ill  = 1'b0;
                    dec.cntl = CNTL_SRA;
                end
                if (!dec.ill) begin
                    dec.a = rs1_data;
                    dec.b = rs2_data;
                end
            end
            OPC_OP_IMM: begin
                dec.ill = 1'b0;
                dec.b   = imm_i;
                unique case (funct3)
                    3'b000: dec.cntl = CNTL_ADD;
                    3'b010: dec.cntl = CNTL_SLT;
                    3'b011: dec.cntl = CNTL_SLTU;
                    3'b100: dec.cntl = CNTL_XOR;
                    3'b110: dec.cntl = CNTL_OR;
                    3'b111: dec.cntl = CNTL_AND;
                    3'b001: begin
                        dec.b = imm_sh;
                        if (funct7 == F7_BASE) dec.cntl = CNTL_SLL;
                        else                   dec.ill  = 1'b1;
                    end
                    default: begin
                        dec.b = imm_sh;
                        if (funct7 == F7_BASE)     dec.cntl = CNTL_SRL;
                        else if (funct7 == F7_ALT) dec.cntl = CNTL_SRA;
                        else                       dec.ill  = 1'b1;
                    end
                endcase
                if (dec.ill) begin
                    dec.cntl = CNTL_ILL;
                    dec.b    = '0;
                end else begin
                    dec.a = rs1_data;
                end
            end
            OPC_LUI: begin
                dec.ill  = 1'b0;
                dec.cntl = CNTL_PASSB;
                dec.b    = imm_u;
            end
            default: ;
        endcase
    end

    // Two-slot circular buffer; the head slot is never written while it is valid.
    entry_t     slot0;
    entry_t     slot1;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = rd_ptr ? slot1 : slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) slot1 <= dec;
                else        slot0 <= dec;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= 16'd0;
        end else if (push && dec.ill && illegal_count != 16'hFFFF) begin
            illegal_count <= illegal_count + 16'd1;
        end
    end

    assign alu_cntl = head.cntl;
    assign alu_a    = head.a;
    assign alu_b    = head.b;
    assign rd       = head.rd;
    assign illegal  = head.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Randomized bench for alu_op_decoder: directed cases plus a queue-based scoreboard
// driven by a table-lookup reference decoder.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_cntl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_count;

    alu_op_decoder #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_cntl(alu_cntl), .alu_a(alu_a), .alu_b(alu_b),
        .rd(rd), .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          model_ic;
    int          n_vec;
    int          n_bad;

    // funct3-indexed codes for the base (funct7=0 / immediate) forms
    logic [3:0] op_tbl [0:7] = '{4'h3, 4'h7, 4'h5, 4'h6, 4'h2, 4'h9, 4'h1, 4'h0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(logic [31:0] i, logic [31:0] r1, logic [31:0] r2);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 0;
        e.c = 4'hF; e.a = 0; e.b = 0; e.rd = i[11:7]; e.ill = 1;
        if (i[6:0] == 7'b0110011) begin
            if (f7 == 7'h00) begin ok = 1; e.c = op_tbl[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.c = 4'h4; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.c = 4'h8; end
            if (ok) begin e.a = r1; e.b = r2; end
        end else if (i[6:0] == 7'b0010011) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) begin ok = 1; e.c = 4'h7; end
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) begin ok = 1; e.c = 4'h9; end
                else if (f7 == 7'h20) begin ok = 1; e.c = 4'h8; end
            end else begin
                ok = 1; e.c = op_tbl[f3];
            end
            if (ok) begin
                e.a = r1;
                if (f3 == 3'd1 || f3 == 3'd5) e.b = 32'(i[24:20]);
                else                          e.b = 32'($signed(i[31:20]));
            end
        end else if (i[6:0] == 7'b0110111) begin
            ok = 1; e.c = 4'hA; e.b = i & 32'hFFFF_F000;
        end
        if (ok) e.ill = 0;
        else    e.c = 4'hF;
        return e;
    endfunction

    // Check current outputs against the model, drive one cycle, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy);
        bit do_push, do_pop;
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("illegal_count", 32'(illegal_count), 32'(model_ic));
        if (q.size() > 0) begin
            check("cntl", 32'(alu_cntl), 32'(q[0].c));
            check("a", alu_a, q[0].a);
            check("b", alu_b, q[0].b);
            check("rd", 32'(rd), 32'(q[0].rd));
            check("illegal", 32'(illegal), 32'(q[0].ill));
        end
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; out_ready = ordy;
        do_pop  = (q.size() > 0) && ordy;
        do_push = v && (q.size() < 2);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            exp_t e;
            e = ref_decode(ins, r1, r2);
            q.push_back(e);
            if (e.ill && model_ic < 65535) model_ic++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 0; out_ready = 0; instr = 0; rs1_data = 0; rs2_data = 0;
        rst_n = 0;
        q.delete();
        model_ic = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int          sel;
        i = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: i[6:0] = 7'b0110011;
            3, 4, 5: i[6:0] = 7'b0010011;
            6:       i[6:0] = 7'b0110111;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return i;
    endfunction

    initial begin
        n_vec = 0; n_bad = 0;
        do_reset();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cntl", 32'(alu_cntl), 32'd0);
        check("rst_a", alu_a, 32'd0);
        check("rst_b", alu_b, 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_icount", 32'(illegal_count), 32'd0);

        // ADD x3,x1,x2
        cycle(1, 32'h002081B3, 32'd5, 32'd7, 1);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_cntl", 32'(alu_cntl), 32'h3);
        check("add_a", alu_a, 32'd5);
        check("add_b", alu_b, 32'd7);
        check("add_rd", 32'(rd), 32'd3);
        check("add_ill", 32'(illegal), 32'd0);
        cycle(0, 0, 0, 0, 1);

        // ADDI x5,x0,-1
        cycle(1, 32'hFFF00293, 32'd0, 32'd0, 1);
        check("addi_cntl", 32'(alu_cntl), 32'h3);
        check("addi_a", alu_a, 32'd0);
        check("addi_b", alu_b, 32'hFFFF_FFFF);
        check("addi_rd", 32'(rd), 32'd5);
        cycle(0, 0, 0, 0, 1);

        // SRAI x6,x7,4
        cycle(1, 32'h4043D313, 32'h8000_0000, 32'd0, 1);
        check("srai_cntl", 32'(alu_cntl), 32'h8);
        check("srai_a", alu_a, 32'h8000_0000);
        check("srai_b", alu_b, 32'd4);
        check("srai_rd", 32'(rd), 32'd6);
        cycle(0, 0, 0, 0, 1);

        // LUI x1,0x12345
        cycle(1, 32'h123450B7, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1);
        check("lui_cntl", 32'(alu_cntl), 32'hA);
        check("lui_a", alu_a, 32'd0);
        check("lui_b", alu_b, 32'h1234_5000);
        check("lui_rd", 32'(rd), 32'd1);
        cycle(0, 0, 0, 0, 1);

        // Illegal: all-zero word, then SUB-form XOR
        cycle(1, 32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 1);
        check("ill0_flag", 32'(illegal), 32'd1);
        check("ill0_cntl", 32'(alu_cntl), 32'hF);
        check("ill0_a", alu_a, 32'd0);
        check("ill0_b", alu_b, 32'd0);
        check("ill0_count", 32'(illegal_count), 32'd1);
        cycle(1, 32'h4020C1B3, 32'h1111_1111, 32'h2222_2222, 1);
        check("ill1_flag", 32'(illegal), 32'd1);
        check("ill1_rd", 32'(rd), 32'd3);
        check("ill1_count", 32'(illegal_count), 32'd2);
        cycle(0, 0, 0, 0, 1);

        // Backpressure: three pushes with out_ready low, then drain in order
        cycle(1, 32'h00208533, 32'd1, 32'd2, 0);   // add x10
        cycle(1, 32'h402085B3, 32'd3, 32'd4, 0);   // sub x11
        cycle(1, 32'h00A00613, 32'd5, 32'd6, 0);   // addi x12,x0,10 (held)
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_rd", 32'(rd), 32'd10);
        cycle(1, 32'h00A00613, 32'd5, 32'd6, 0);   // stalled, head must not move
        check("bp_stable_rd", 32'(rd), 32'd10);
        check("bp_stable_a", alu_a, 32'd1);
        cycle(1, 32'h00A00613, 32'd5, 32'd6, 1);
        check("bp_rd2", 32'(rd), 32'd11);
        check("bp_cntl2", 32'(alu_cntl), 32'h4);
        check("bp_in_ready2", 32'(in_ready), 32'd1);
        cycle(1, 32'h00A00613, 32'd5, 32'd6, 1);
        check("bp_rd3", 32'(rd), 32'd12);
        check("bp_b3", alu_b, 32'd10);
        cycle(0, 0, 0, 0, 1);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two entries buffered
        cycle(1, 32'h00000000, 32'd0, 32'd0, 0);
        cycle(1, 32'h002081B3, 32'd8, 32'd9, 0);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        in_valid = 0;
        rst_n = 0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_icount", 32'(illegal_count), 32'd0);
        do_reset();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Random traffic against the scoreboard
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 200; n++) begin
            cycle(1, rand_instr(), $urandom, $urandom, 1);
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Saturation of illegal_count
        do_reset();
        in_valid = 1; instr = 32'h0000_0000; out_ready = 1;
        repeat (65540) @(negedge clk);
        check("sat_count", 32'(illegal_count), 32'hFFFF);
        repeat (10) @(negedge clk);
        check("sat_hold", 32'(illegal_count), 32'hFFFF);
        check("sat_flow", 32'(out_valid), 32'd1);
        do_reset();
        check("final_icount", 32'(illegal_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
